// File: rtl/pc_redirect_unit.sv
`default_nettype none
// ============================================================================
// Module   : pc_redirect_unit
// Purpose  : Fetch PC register with jump/branch redirect, stall deferral,
//            IF/ID flush, sticky misalignment flag and saturating counter.
// Revision : 1.0 - initial release
// ============================================================================
module pc_redirect_unit #(
    parameter int              PC_W     = 32,
    parameter logic [PC_W-1:0] RESET_PC = '0,
    parameter int              CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic [1:0]       jump_op,
    input  logic [PC_W-1:0]  id_pc4,
    input  logic [PC_W-1:0]  branch_target,
    input  logic [25:0]      jump_index,
    input  logic [PC_W-1:0]  reg_target,
    output logic [PC_W-1:0]  pc_out,
    output logic             flush,
    output logic             pending,
    output logic             misalign_err,
    output logic [CNT_W-1:0] redirect_cnt
);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_PEND = 1'b1
    } state_t;

    localparam logic [PC_W-1:0]  c_pc_step = PC_W'(4);
    localparam logic [CNT_W-1:0] c_cnt_max = '1;
    localparam logic [1:0]       c_op_seq  = 2'b00;
    localparam logic [1:0]       c_op_br   = 2'b01;
    localparam logic [1:0]       c_op_reg  = 2'b10;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [PC_W-1:0]   r_pc;
    logic [PC_W-1:0]   r_pend_target;
    logic [PC_W-1:0]   w_pc_nxt;
    logic [PC_W-1:0]   w_pend_nxt;
    logic [PC_W-1:0]   w_target;
    logic              w_redirect;
    logic              w_mis_set;
    logic              r_misalign;
    logic [CNT_W-1:0]  r_cnt;
    logic              w_unused;

    // Only the region bits of id_pc4 take part in the j/jal target.
    assign w_unused = ^id_pc4[27:0];

    always_comb begin
        w_target = {id_pc4[PC_W-1:28], jump_index, 2'b00};
        case (jump_op)
            c_op_br:  w_target = {branch_target[PC_W-1:2], 2'b00};
            c_op_reg: w_target = {reg_target[PC_W-1:2], 2'b00};
            default:  w_target = {id_pc4[PC_W-1:28], jump_index, 2'b00};
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_pend_nxt  = r_pend_target;
        w_redirect  = 1'b0;
        w_mis_set   = 1'b0;
        case (r_state)
            S_IDLE: begin
                // Any non-seq op in IDLE is either applied or captured.
                w_mis_set = (jump_op == c_op_reg) && (reg_target[1:0] != 2'b00);
                if (!stall) begin
                    if (jump_op == c_op_seq) begin
                        w_pc_nxt = r_pc + c_pc_step;
                    end else begin
                        w_pc_nxt   = w_target;
                        w_redirect = 1'b1;
                    end
                end else if (jump_op != c_op_seq) begin
                    w_pend_nxt  = w_target;
                    w_state_nxt = S_PEND;
                end
            end
            S_PEND: begin
                if (!stall) begin
                    w_pc_nxt    = r_pend_target;
                    w_redirect  = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_pc          <= RESET_PC;
            r_pend_target <= '0;
            r_misalign    <= 1'b0;
            r_cnt         <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_pc          <= w_pc_nxt;
            r_pend_target <= w_pend_nxt;
            if (w_mis_set) begin
                r_misalign <= 1'b1;
            end
            if (w_redirect && (r_cnt != c_cnt_max)) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign pc_out       = r_pc;
    assign flush        = w_redirect & ~rst;
    assign pending      = (r_state == S_PEND);
    assign misalign_err = r_misalign;
    assign redirect_cnt = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_pc_redirect_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_pc_redirect_unit
// Purpose  : Directed plus random stimulus against a behavioural PC model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pc_redirect_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic [1:0]  jump_op;
    logic [31:0] id_pc4;
    logic [31:0] branch_target;
    logic [25:0] jump_index;
    logic [31:0] reg_target;
    logic [31:0] pc_out,  pc_out_s;
    logic        flush,   flush_s;
    logic        pending, pending_s;
    logic        misalign_err, misalign_err_s;
    logic [15:0] redirect_cnt;
    logic [1:0]  redirect_cnt_s;

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    // Model state
    logic [31:0] m_pc;
    bit          m_pend;
    logic [31:0] m_tgt;
    bit          m_mis;
    int          m_cnt;

    always #5 clk = ~clk;

    pc_redirect_unit dut (
        .clk(clk), .rst(rst), .stall(stall), .jump_op(jump_op),
        .id_pc4(id_pc4), .branch_target(branch_target),
        .jump_index(jump_index), .reg_target(reg_target),
        .pc_out(pc_out), .flush(flush), .pending(pending),
        .misalign_err(misalign_err), .redirect_cnt(redirect_cnt)
    );

    pc_redirect_unit #(.CNT_W(2)) dut_s (
        .clk(clk), .rst(rst), .stall(stall), .jump_op(jump_op),
        .id_pc4(id_pc4), .branch_target(branch_target),
        .jump_index(jump_index), .reg_target(reg_target),
        .pc_out(pc_out_s), .flush(flush_s), .pending(pending_s),
        .misalign_err(misalign_err_s), .redirect_cnt(redirect_cnt_s)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model_target(input logic [1:0] op);
        case (op)
            2'd1:    return branch_target & 32'hFFFF_FFFC;
            2'd2:    return reg_target & 32'hFFFF_FFFC;
            default: return (id_pc4 & 32'hF000_0000) | (32'(jump_index) * 4);
        endcase
    endfunction

    function automatic int sat(input int v, input int mx);
        return (v > mx) ? mx : v;
    endfunction

    task automatic step(input logic r, input logic s, input logic [1:0] op,
                        input logic [31:0] pc4, input logic [31:0] bt,
                        input logic [25:0] ji, input logic [31:0] rt);
        bit exp_flush;
        rst = r; stall = s; jump_op = op; id_pc4 = pc4;
        branch_target = bt; jump_index = ji; reg_target = rt;
        #2;
        exp_flush = !r && (m_pend ? !s : (!s && op != 2'd0));
        check("flush", 64'(flush), 64'(exp_flush));
        check("flush_s", 64'(flush_s), 64'(exp_flush));
        @(posedge clk);
        if (r) begin
            m_pc = 32'h0; m_pend = 0; m_tgt = 32'h0; m_mis = 0; m_cnt = 0;
        end else if (m_pend) begin
            if (!s) begin m_pc = m_tgt; m_pend = 0; m_cnt++; end
        end else if (op != 2'd0) begin
            if (op == 2'd2 && rt[1:0] != 2'b00) m_mis = 1;
            if (s) begin m_pend = 1; m_tgt = model_target(op); end
            else begin m_pc = model_target(op); m_cnt++; end
        end else if (!s) begin
            m_pc = m_pc + 32'd4;
        end
        #1;
        check("pc_out", 64'(pc_out), 64'(m_pc));
        check("pending", 64'(pending), 64'(m_pend));
        check("misalign", 64'(misalign_err), 64'(m_mis));
        check("cnt16", 64'(redirect_cnt), 64'(sat(m_cnt, 65535)));
        check("pc_out_s", 64'(pc_out_s), 64'(m_pc));
        check("cnt2", 64'(redirect_cnt_s), 64'(sat(m_cnt, 3)));
    endtask

    task automatic seq(input logic s);
        step(1'b0, s, 2'd0, 32'h0, 32'h0, 26'h0, 32'h0);
    endtask

    initial begin
        m_pc = 32'h0; m_pend = 0; m_tgt = 32'h0; m_mis = 0; m_cnt = 0;
        #1;
        // 1: reset then sequential fetch
        step(1'b1, 1'b0, 2'd3, 32'h1234_5678, 32'h0, 26'h3FF_FFFF, 32'h0);
        step(1'b1, 1'b0, 2'd0, 32'h0, 32'h0, 26'h0, 32'h0);
        check("reset_pc", 64'(pc_out), 64'h0);
        for (int i = 0; i < 4; i++) seq(1'b0);
        check("pc_16", 64'(pc_out), 64'd16);

        // 2: j/jal
        step(1'b0, 1'b0, 2'd3, 32'h1000_0008, 32'h0, 26'h000_0040, 32'h0);
        check("jump_pc", 64'(pc_out), 64'h1000_0100);
        check("jump_cnt", 64'(redirect_cnt), 64'd1);

        // 3: branch deferred by stall; later jump_op ignored
        step(1'b0, 1'b1, 2'd1, 32'h0, 32'h0000_0200, 26'h0, 32'h0);
        step(1'b0, 1'b1, 2'd3, 32'h0, 32'h0, 26'h0AB_CDEF, 32'h0);
        step(1'b0, 1'b1, 2'd0, 32'h0, 32'h0, 26'h0, 32'h0);
        check("pend_hold", 64'(pending), 64'd1);
        step(1'b0, 1'b0, 2'd3, 32'h0, 32'h0, 26'h055_5555, 32'h0);
        check("pend_apply", 64'(pc_out), 64'h200);

        // 4: misaligned register target, sticky
        step(1'b0, 1'b0, 2'd2, 32'h0, 32'h0, 26'h0, 32'h0000_0403);
        check("jr_pc", 64'(pc_out), 64'h400);
        step(1'b0, 1'b0, 2'd2, 32'h0, 32'h0, 26'h0, 32'h0000_0800);
        step(1'b0, 1'b0, 2'd1, 32'h0, 32'h0000_0300, 26'h0, 32'h0);
        check("mis_sticky", 64'(misalign_err), 64'd1);

        // 5: PC wrap; small counter already saturated after 5+ redirects
        step(1'b0, 1'b0, 2'd2, 32'h0, 32'h0, 26'h0, 32'hFFFF_FFFC);
        seq(1'b0);
        check("pc_wrap", 64'(pc_out), 64'h0);
        check("cnt2_sat", 64'(redirect_cnt_s), 64'd3);

        // 6: reset while pending discards the held target
        step(1'b0, 1'b1, 2'd1, 32'h0, 32'h0000_0ABC, 26'h0, 32'h0);
        step(1'b1, 1'b0, 2'd0, 32'h0, 32'h0, 26'h0, 32'h0);
        check("rst_pend", 64'(pending), 64'd0);
        seq(1'b0);
        check("rst_discard", 64'(pc_out), 64'd4);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            logic [31:0] rt;
            rt = $urandom;
            if ($urandom_range(0, 3) != 0) rt[1:0] = 2'b00;
            step(($urandom_range(0, 39) == 0), ($urandom_range(0, 9) < 3),
                 2'($urandom_range(0, 3)), $urandom, $urandom,
                 26'($urandom), rt);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
